// File: rtl/dt_pkg.sv
// Shared types and node-word layout helpers for the decision-tree stream classifier.
// Node word, MSB first: {is_leaf, cls[C], fidx[FW], thr[W], left[AW], right[AW]}.
package dt_pkg;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  localparam int unsigned MAX_NODE_W = 128;
  localparam int unsigned OFF_RIGHT  = 0;

  typedef logic [MAX_NODE_W-1:0] node_word_t;

  function automatic int unsigned aw_of(input int unsigned nodes);
    return $clog2(nodes);
  endfunction

  function automatic int unsigned fw_of(input int unsigned n_feat);
    return $clog2(n_feat);
  endfunction

  function automatic int unsigned node_w(input int unsigned w, n_feat, c, nodes);
    return 1 + c + fw_of(n_feat) + w + 2 * aw_of(nodes);
  endfunction

  function automatic int unsigned off_left(input int unsigned nodes);
    return aw_of(nodes);
  endfunction

  function automatic int unsigned off_thr(input int unsigned nodes);
    return 2 * aw_of(nodes);
  endfunction

  function automatic int unsigned off_fidx(input int unsigned w, nodes);
    return 2 * aw_of(nodes) + w;
  endfunction

  function automatic int unsigned off_cls(input int unsigned w, n_feat, nodes);
    return 2 * aw_of(nodes) + w + fw_of(n_feat);
  endfunction

  // Leaf word carrying the given class; the caller slices it to its node width.
  function automatic node_word_t leaf_word(input int unsigned w, n_feat, c, nodes,
                                           input node_word_t cls);
    node_word_t word;
    word = '0;
    word[node_w(w, n_feat, c, nodes) - 1] = 1'b1;
    word = word | (cls << off_cls(w, n_feat, nodes));
    return word;
  endfunction

endpackage

// File: rtl/dt_stream_classifier_if.sv
// Config, feature-input and class-output streams of dt_stream_classifier.
// master = feature front-end / configurator / logger side, slave = classifier.
interface dt_stream_classifier_if #(
  parameter int unsigned W      = 8,
  parameter int unsigned N_FEAT = 6,
  parameter int unsigned C      = 1,
  parameter int unsigned NODES  = 32
);
  import dt_pkg::*;

  localparam int unsigned AW     = aw_of(NODES);
  localparam int unsigned NODE_W = node_w(W, N_FEAT, C, NODES);

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [NODE_W-1:0] cfg_wdata;
  logic              cfg_ready;

  logic                in_valid;
  logic                in_ready;
  logic [N_FEAT*W-1:0] in_feat;

  logic         out_valid;
  logic         out_ready;
  logic [C-1:0] out_cls;
  logic         out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    input  cfg_ready, in_ready, out_valid, out_cls, out_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    output cfg_ready, in_ready, out_valid, out_cls, out_err
  );

endinterface

// File: rtl/dt_node_mem.sv
// Node table: NODES x NODE_W flop array, one write port, asynchronous read,
// asynchronous reset of every entry to RST_WORD.
module dt_node_mem #(
  parameter int unsigned      NODES    = 32,
  parameter int unsigned      NODE_W   = 23,
  parameter logic [NODE_W-1:0] RST_WORD = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NODES)-1:0] waddr,
  input  logic [NODE_W-1:0]        wdata,
  input  logic [$clog2(NODES)-1:0] raddr,
  output logic [NODE_W-1:0]        rdata
);

  logic [NODE_W-1:0] mem [NODES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NODES; i++) mem[i] <= RST_WORD;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dt_stream_classifier.sv
// Runtime-programmable decision-tree classifier walking one node per clock.
// Optional step watchdog enabled by defining DT_WATCHDOG_EN.
module dt_stream_classifier
  import dt_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned N_FEAT    = 6,
  parameter int unsigned C         = 1,
  parameter int unsigned NODES     = 32,
  parameter int unsigned MAX_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dt_stream_classifier_if.slave  bus,
  output logic                   busy
);

  localparam int unsigned AW     = aw_of(NODES);
  localparam int unsigned FW     = fw_of(N_FEAT);
  localparam int unsigned NODE_W = node_w(W, N_FEAT, C, NODES);
  localparam int unsigned O_LEFT = off_left(NODES);
  localparam int unsigned O_THR  = off_thr(NODES);
  localparam int unsigned O_FIDX = off_fidx(W, NODES);
  localparam int unsigned O_CLS  = off_cls(W, N_FEAT, NODES);
  localparam node_word_t        RST_FULL = leaf_word(W, N_FEAT, C, NODES, '0);
  localparam logic [NODE_W-1:0] RST_WORD = RST_FULL[NODE_W-1:0];

  if (NODES < 2 || (NODES & (NODES - 1)) != 0 || N_FEAT < 2 || MAX_DEPTH < 1) begin : g_param_check
    $error("dt_stream_classifier: unsupported parameter set");
  end

  state_t                  state;
  logic [AW-1:0]           ptr;
  logic [N_FEAT-1:0][W-1:0] feat;
  logic [NODE_W-1:0]       node;
  logic                    node_leaf;
  logic [C-1:0]            node_cls;
  logic [FW-1:0]           node_fidx;
  logic [W-1:0]            node_thr;
  logic [AW-1:0]           node_left;
  logic [AW-1:0]           node_right;
  logic [W-1:0]            fval;
  logic                    cfg_write;

  assign node_leaf  = node[NODE_W-1];
  assign node_cls   = node[O_CLS +: C];
  assign node_fidx  = node[O_FIDX +: FW];
  assign node_thr   = node[O_THR +: W];
  assign node_left  = node[O_LEFT +: AW];
  assign node_right = node[OFF_RIGHT +: AW];

  // Out-of-range feature indices fall through to a zero operand.
  always_comb begin
    fval = '0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (node_fidx == FW'(i)) fval = feat[i];
    end
  end

  assign bus.cfg_ready = (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign busy          = (state != IDLE);
  assign cfg_write     = bus.cfg_we & (state == IDLE);

  dt_node_mem #(
    .NODES    (NODES),
    .NODE_W   (NODE_W),
    .RST_WORD (RST_WORD)
  ) u_node_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_write),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_wdata),
    .raddr (ptr),
    .rdata (node)
  );

`ifdef DT_WATCHDOG_EN
  localparam int unsigned SW = $clog2(MAX_DEPTH + 1);
  logic [SW-1:0] steps;
`else
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      feat          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_cls   <= '0;
`ifdef DT_WATCHDOG_EN
      bus.out_err   <= 1'b0;
      steps         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            feat  <= bus.in_feat;
            ptr   <= '0;
            state <= WALK;
`ifdef DT_WATCHDOG_EN
            steps <= '0;
`endif
          end
        end
        WALK: begin
          if (node_leaf) begin
            bus.out_cls   <= node_cls;
            bus.out_valid <= 1'b1;
            state         <= DONE;
`ifdef DT_WATCHDOG_EN
            bus.out_err   <= 1'b0;
          end else if (steps == SW'(MAX_DEPTH)) begin
            bus.out_cls   <= '0;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= DONE;
`endif
          end else begin
            ptr <= (fval < node_thr) ? node_left : node_right;
`ifdef DT_WATCHDOG_EN
            steps <= steps + 1'b1;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_stream_classifier.sv
// Self-checking bench for dt_stream_classifier against a table-walking reference model.
// Honours DT_WATCHDOG_EN the same way as the RTL.
module tb_dt_stream_classifier;

  localparam int W = 8, N_FEAT = 6, C = 1, NODES = 32, MAX_DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic exp_cls = 1'b0;
  logic exp_err = 1'b0;
  logic last_cls;
  logic last_err;
  int   last_lat;

  bit m_leaf [NODES];
  bit m_cls  [NODES];
  int m_fidx [NODES];
  int m_thr  [NODES];
  int m_left [NODES];
  int m_right[NODES];

  dt_stream_classifier_if #(.W(W), .N_FEAT(N_FEAT), .C(C), .NODES(NODES)) bus ();

  dt_stream_classifier #(
    .W(W), .N_FEAT(N_FEAT), .C(C), .NODES(NODES), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every cycle a result is presented it must match the model's verdict for the accepted vector.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      checks++;
      if (bus.out_cls !== exp_cls || bus.out_err !== exp_err || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL result: cls=%0d err=%0d in_ready=%0d expected cls=%0d err=%0d in_ready=0",
                 bus.out_cls, bus.out_err, bus.in_ready, exp_cls, exp_err);
      end
    end
  end

  function automatic logic [22:0] pack(input bit leaf, input bit cls, input int fidx,
                                       input int thr, input int l, input int r);
    return {leaf, cls, 3'(fidx), 8'(thr), 5'(l), 5'(r)};
  endfunction

  function automatic void model_set(input int idx, input bit leaf, input bit cls, input int fidx,
                                    input int thr, input int l, input int r);
    m_leaf[idx] = leaf; m_cls[idx] = cls; m_fidx[idx] = fidx;
    m_thr[idx] = thr; m_left[idx] = l; m_right[idx] = r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NODES; i++) model_set(i, 1'b1, 1'b0, 0, 0, 0, 0);
  endfunction

  // Follow the table from the root; depth = number of internal nodes passed.
  function automatic void model_walk(input logic [47:0] f, output bit cls, output int depth,
                                     output bit err);
    int ptr, v;
    bit done;
    ptr = 0; depth = 0; err = 1'b0; cls = 1'b0; done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      if (m_leaf[ptr]) begin
        cls = m_cls[ptr];
        done = 1'b1;
      end
`ifdef DT_WATCHDOG_EN
      else if (depth == MAX_DEPTH) begin
        err = 1'b1;
        done = 1'b1;
      end
`endif
      else begin
        v = (m_fidx[ptr] < N_FEAT) ? int'((f >> (8 * m_fidx[ptr])) & 48'hFF) : 0;
        ptr = (v < m_thr[ptr]) ? m_left[ptr] : m_right[ptr];
        depth++;
      end
    end
    if (!done) err = 1'b1;
  endfunction

  task automatic program_node(input int idx, input bit leaf, input bit cls, input int fidx,
                              input int thr, input int l, input int r);
    @(negedge clk);
    chk("cfg_ready_idle", bus.cfg_ready, 1);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 5'(idx);
    bus.cfg_wdata = pack(leaf, cls, fidx, thr, l, r);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    model_set(idx, leaf, cls, fidx, thr, l, r);
  endtask

  // One vector end to end. drop_wr: write node1=leaf cls0 during WALK (must be ignored).
  // co_wr: same write on the accepting edge (must take effect for this walk).
  task automatic send_vec(input logic [47:0] f, input int hold, input bit drop_wr, input bit co_wr);
    bit   mcls, merr;
    int   mdepth, a, k;
    @(negedge clk);
    chk("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_feat = f;
    bus.out_ready = 1'b0;
    if (co_wr) begin
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 5'd1;
      bus.cfg_wdata = pack(1, 0, 0, 0, 0, 0);
      model_set(1, 1'b1, 1'b0, 0, 0, 0, 0);
    end
    model_walk(f, mcls, mdepth, merr);
    a = cyc;
    @(posedge clk);
    exp_cls = mcls;
    exp_err = merr;
    #1;
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b0;
    @(negedge clk);
    if (drop_wr) begin
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 5'd1;
      bus.cfg_wdata = pack(1, 0, 0, 0, 0, 0);
    end
    k = 0;
    while (!bus.out_valid && k < 200) begin
      @(negedge clk);
      bus.cfg_we = 1'b0;
      k++;
    end
    bus.cfg_we = 1'b0;
    if (!bus.out_valid) begin
      chk("out_valid_timeout", 0, 1);
      last_cls = 1'bx; last_err = 1'bx; last_lat = -1;
      return;
    end
    last_cls = bus.out_cls;
    last_err = bus.out_err;
    last_lat = cyc - (a + 1);
    chk("latency_vs_model", last_lat, mdepth + 1);
    for (int h = 0; h < hold; h++) begin
      chk("in_ready_in_done", bus.in_ready, 0);
      chk("cfg_ready_in_done", bus.cfg_ready, 0);
      @(negedge clk);
    end
    chk("out_valid_held", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_dropped", bus.out_valid, 0);
    chk("in_ready_after_release", bus.in_ready, 1);
  endtask

  function automatic logic [47:0] with_ib(input int ib);
    logic [47:0] f;
    f = {$urandom, $urandom};
    f[32 +: 8] = 8'(ib);
    return f;
  endfunction

  task automatic random_tree();
    int lvl;
    for (int i = 0; i < NODES; i++) begin
      lvl = i / 4;
      if (lvl == 7 || (i != 0 && $urandom_range(0, 3) == 0))
        program_node(i, 1'b1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      else
        program_node(i, 1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 255),
                     4 * (lvl + 1) + $urandom_range(0, 3), 4 * (lvl + 1) + $urandom_range(0, 3));
    end
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.in_valid = 1'b0; bus.in_feat = '0; bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_cls", bus.out_cls, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cfg_ready", bus.cfg_ready, 1);

    // Unprogrammed table: root is a class-0 leaf.
    send_vec(48'hFFFF_FFFF_FFFF, 0, 0, 0);
    chk("t1_cls", last_cls, 0);
    chk("t1_err", last_err, 0);
    chk("t1_latency", last_lat, 1);

    // Ib < 119 -> node1 (cls1), else node2 (cls0).
    program_node(0, 1'b0, 1'b0, 4, 119, 1, 2);
    program_node(1, 1'b1, 1'b1, 0, 0, 0, 0);
    program_node(2, 1'b1, 1'b0, 0, 0, 0, 0);
    send_vec(with_ib(100), 0, 0, 0);
    chk("t2_ib100_cls", last_cls, 1);
    chk("t2_ib100_latency", last_lat, 2);
    send_vec(with_ib(119), 0, 0, 0);
    chk("t2_ib119_cls", last_cls, 0);
    send_vec(with_ib(118), 0, 0, 0);
    chk("t2_ib118_cls", last_cls, 1);

    send_vec(with_ib(100), 5, 0, 0);
    chk("t3_held_cls", last_cls, 1);

    send_vec(with_ib(100), 0, 1, 0);
    chk("t4_dropped_write_cls", last_cls, 1);
    send_vec(with_ib(100), 0, 0, 1);
    chk("t4_same_edge_write_cls", last_cls, 0);
    chk("t4_same_edge_latency", last_lat, 2);

    // Self-loop at the root.
    program_node(0, 1'b0, 1'b0, 0, 255, 0, 0);
`ifdef DT_WATCHDOG_EN
    send_vec(48'h0, 0, 0, 0);
    chk("t5_wd_err", last_err, 1);
    chk("t5_wd_cls", last_cls, 0);
    chk("t5_wd_latency", last_lat, MAX_DEPTH + 1);
`endif
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_feat = 48'h0;
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef DT_WATCHDOG_EN
    repeat (8) @(negedge clk);
`else
    repeat (40) @(negedge clk);
`endif
    chk("t5_busy_cyclic", busy, 1);
    chk("t5_no_result_cyclic", bus.out_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_async_in_ready", bus.in_ready, 1);
    chk("t5_async_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_vec(48'h0, 0, 0, 0);
    chk("t5_cleared_cls", last_cls, 0);
    chk("t5_cleared_latency", last_lat, 1);

    for (int t = 0; t < 4; t++) begin
      random_tree();
      for (int n = 0; n < 250; n++)
        send_vec({$urandom, $urandom}, $urandom_range(0, 2), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
